// File: rtl/mdu_if.sv
// Handshake and data bundle between the controller/datapath and the multiply/divide unit.
// The master drives the operation request and MTHI/MTLO writes; the slave returns status and HI/LO.
interface mdu_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             wr_hi;
    logic             wr_lo;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, a, b, wr_hi, wr_lo,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, a, b, wr_hi, wr_lo,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/mdu.sv
// Iterative MIPS multiply/divide unit: MULT/MULTU by shift-add, DIV/DIVU by restoring division,
// one bit per cycle into HI/LO, plus direct MTHI/MTLO writes.
module mdu #(
    parameter int WIDTH = 32
) (
    input  logic  clk,
    input  logic  reset,
    mdu_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t             state, state_next;
    logic [4:0]         cnt;
    logic               busy_q, done_q;
    logic [WIDTH-1:0]   hi_q, lo_q;

    // Working registers, loaded at launch.
    logic               is_div;
    logic               sign_a, sign_b;
    logic               b_zero;
    logic [WIDTH-1:0]   a_raw;
    logic [WIDTH-1:0]   opnd;
    logic [2*WIDTH-1:0] acc;

    logic               launch;
    logic               in_sign_a, in_sign_b;
    logic [WIDTH-1:0]   in_mag_a, in_mag_b;

    logic [WIDTH:0]     mul_sum, div_shift, div_trial;
    logic [2*WIDTH-1:0] acc_step, prod;
    logic [WIDTH-1:0]   res_hi, res_lo;

    assign launch    = (state == IDLE) && bus.start;
    assign in_sign_a = ~bus.op[0] & bus.a[WIDTH-1];
    assign in_sign_b = ~bus.op[0] & bus.b[WIDTH-1];
    assign in_mag_a  = in_sign_a ? -bus.a : bus.a;
    assign in_mag_b  = in_sign_b ? -bus.b : bus.b;

    // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // NOTE: default first so no path leaves state_next unassigned and infers a latch.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.start) state_next = RUN;
            RUN:     if (cnt == 5'd31) state_next = FIX;
            FIX:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // One iteration. Multiply keeps the multiplier in acc's low half and shifts the partial
    // product in from the top; divide keeps remainder:quotient in acc and shifts left.
    always_comb begin
        mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
        div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        div_trial = div_shift - {1'b0, opnd};
        if (!is_div)
            acc_step = {mul_sum, acc[WIDTH-1:1]};
        else if (div_trial[WIDTH])
            acc_step = {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
        else
            acc_step = {div_trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    end

    // Sign correction; the divide-overflow case wraps naturally in WIDTH-bit arithmetic.
    always_comb begin
        prod   = (sign_a ^ sign_b) ? -acc : acc;
        res_hi = prod[2*WIDTH-1:WIDTH];
        res_lo = prod[WIDTH-1:0];
        if (is_div) begin
            if (b_zero) begin
                res_hi = a_raw;
                res_lo = '1;
            end else begin
                res_lo = (sign_a ^ sign_b) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
                res_hi = sign_a ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
            end
        end
    end

    // NOTE: working registers carry no reset; launch always loads them before they are read.
    always_ff @(posedge clk) begin
        if (launch) begin
            is_div <= bus.op[1];
            sign_a <= in_sign_a;
            sign_b <= in_sign_b;
            b_zero <= (bus.b == '0);
            a_raw  <= bus.a;
            opnd   <= bus.op[1] ? in_mag_b : in_mag_a;
            acc    <= {{WIDTH{1'b0}}, (bus.op[1] ? in_mag_a : in_mag_b)};
        end else if (state == RUN) begin
            acc <= acc_step;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt    <= 5'd0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            hi_q   <= '0;
            lo_q   <= '0;
        end else begin
            busy_q <= (state_next != IDLE);
            done_q <= (state == FIX);
            cnt    <= (state == RUN) ? cnt + 5'd1 : 5'd0;
            if (state == FIX) begin
                hi_q <= res_hi;
                lo_q <= res_lo;
            end else if (state == IDLE && !bus.start) begin
                if (bus.wr_hi) hi_q <= bus.a;
                if (bus.wr_lo) lo_q <= bus.a;
            end
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;
endmodule

// File: tb/tb_mdu.sv
// Self-checking bench for mdu: directed corner cases plus randomized operations,
// compared against a reference model using plain 64-bit arithmetic.
module tb_mdu;
    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    mdu_if #(.WIDTH(32)) bus ();

    mdu #(.WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int          checks   = 0;
    int          failures = 0;
    logic [31:0] m_hi, m_lo;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Returns {HI, LO} as the architecture defines them.
    function automatic logic [63:0] ref_result(input logic [1:0] op, input logic [31:0] a,
                                               input logic [31:0] b);
        longint      sa, sb, q, r;
        logic [63:0] qv, rv, p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            2'd0: begin
                p = sa * sb;
                return p;
            end
            2'd1: begin
                p = {32'd0, a} * {32'd0, b};
                return p;
            end
            2'd2: begin
                if (b == 32'd0) return {a, 32'hFFFFFFFF};
                q  = sa / sb;
                r  = sa % sb;
                qv = q;
                rv = r;
                return {rv[31:0], qv[31:0]};
            end
            default: begin
                if (b == 32'd0) return {a, 32'hFFFFFFFF};
                qv = {32'd0, a / b};
                rv = {32'd0, a % b};
                return {rv[31:0], qv[31:0]};
            end
        endcase
    endfunction

    task automatic idle_inputs();
        bus.start = 1'b0;
        bus.wr_hi = 1'b0;
        bus.wr_lo = 1'b0;
        bus.op    = 2'd0;
        bus.a     = 32'd0;
        bus.b     = 32'd0;
    endtask

    // Called at a negedge in IDLE; returns at the negedge of the done cycle.
    task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input bit with_wr);
        logic [63:0] r;
        int          busy_cnt;
        bit          hold_bad, done_bad;
        r         = ref_result(op, a, b);
        bus.start = 1'b1;
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        bus.wr_hi = with_wr;
        bus.wr_lo = with_wr;
        @(negedge clk);
        busy_cnt = 0;
        hold_bad = 1'b0;
        done_bad = 1'b0;
        while (bus.busy && busy_cnt < 40) begin
            if (bus.hi !== m_hi || bus.lo !== m_lo) hold_bad = 1'b1;
            if (bus.done) done_bad = 1'b1;
            busy_cnt++;
            bus.start = 1'($urandom_range(0, 1));
            bus.wr_hi = 1'($urandom_range(0, 1));
            bus.wr_lo = 1'($urandom_range(0, 1));
            bus.op    = 2'($urandom_range(0, 3));
            bus.a     = $urandom;
            bus.b     = $urandom;
            @(negedge clk);
        end
        idle_inputs();
        m_hi = r[63:32];
        m_lo = r[31:0];
        check({tag, ".latency"}, 64'(busy_cnt), 64'd33);
        check({tag, ".hold"}, 64'(hold_bad), 64'd0);
        check({tag, ".done_early"}, 64'(done_bad), 64'd0);
        check({tag, ".done"}, 64'(bus.done), 64'd1);
        check({tag, ".hi"}, 64'(bus.hi), 64'(m_hi));
        check({tag, ".lo"}, 64'(bus.lo), 64'(m_lo));
    endtask

    task automatic after_done(input string tag);
        @(negedge clk);
        check({tag, ".done_once"}, 64'(bus.done), 64'd0);
        check({tag, ".idle"}, 64'(bus.busy), 64'd0);
    endtask

    task automatic mt_write(input string tag, input bit wh, input bit wl, input logic [31:0] d);
        bus.wr_hi = wh;
        bus.wr_lo = wl;
        bus.a     = d;
        @(negedge clk);
        idle_inputs();
        if (wh) m_hi = d;
        if (wl) m_lo = d;
        check({tag, ".hi"}, 64'(bus.hi), 64'(m_hi));
        check({tag, ".lo"}, 64'(bus.lo), 64'(m_lo));
        check({tag, ".no_done"}, 64'(bus.done), 64'd0);
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 6))
            0:       return 32'd0;
            1:       return 32'hFFFFFFFF;
            2:       return 32'h80000000;
            3:       return 32'd1;
            4:       return 32'($urandom_range(0, 20));
            5:       return 32'hFFFFFFFF - 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        idle_inputs();
        reset = 1'b1;
        m_hi  = 32'd0;
        m_lo  = 32'd0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check("rst.busy", 64'(bus.busy), 64'd0);
        check("rst.done", 64'(bus.done), 64'd0);
        check("rst.hi", 64'(bus.hi), 64'd0);
        check("rst.lo", 64'(bus.lo), 64'd0);

        mt_write("mthi", 1'b1, 1'b0, 32'h12345678);
        run_op("multu_2x3", 2'd1, 32'd2, 32'd3, 1'b0);
        after_done("multu_2x3");

        run_op("multu_max", 2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
        after_done("multu_max");

        run_op("mult_neg", 2'd0, 32'hFFFFFFFD, 32'd7, 1'b0);
        run_op("divu_b2b", 2'd3, 32'd7, 32'd2, 1'b0);
        after_done("divu_b2b");

        run_op("div_neg", 2'd2, 32'hFFFFFFF9, 32'd2, 1'b0);
        run_op("div_ovf", 2'd2, 32'h80000000, 32'hFFFFFFFF, 1'b0);
        run_op("div_zero", 2'd2, 32'd5, 32'd0, 1'b0);
        run_op("divu_zero", 2'd3, 32'h80000001, 32'd0, 1'b0);
        after_done("divu_zero");

        run_op("start_wr", 2'd1, 32'd5, 32'd6, 1'b1);
        mt_write("mtboth", 1'b1, 1'b1, 32'hA5A5A5A5);
        mt_write("mtlo", 1'b0, 1'b1, 32'h0BADF00D);

        // Abort an operation with reset, then restart immediately.
        bus.start = 1'b1;
        bus.op    = 2'd3;
        bus.a     = 32'd100;
        bus.b     = 32'd7;
        @(negedge clk);
        idle_inputs();
        repeat (9) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        m_hi  = 32'd0;
        m_lo  = 32'd0;
        check("abort.busy", 64'(bus.busy), 64'd0);
        check("abort.done", 64'(bus.done), 64'd0);
        check("abort.hi", 64'(bus.hi), 64'd0);
        check("abort.lo", 64'(bus.lo), 64'd0);
        run_op("divu_after_rst", 2'd3, 32'd100, 32'd7, 1'b0);
        after_done("divu_after_rst");

        for (int i = 0; i < 24; i++) begin
            logic [1:0]  rop;
            logic [31:0] ra, rb;
            rop = 2'($urandom_range(0, 3));
            ra  = pick_operand();
            rb  = pick_operand();
            run_op($sformatf("rnd%0d", i), rop, ra, rb, 1'($urandom_range(0, 1)));
            case ($urandom_range(0, 2))
                0: ;
                1: after_done($sformatf("rnd%0d", i));
                default: mt_write($sformatf("rnd%0d.mt", i), 1'($urandom_range(0, 1)),
                                  1'($urandom_range(0, 1)), $urandom);
            endcase
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
